// File: rtl/rf_write_arbiter.sv
// Two-lane writeback arbiter for the single register-file write port, with per-lane hold buffers.
// Optional saturating statistics counters when RF_WRITE_ARB_STATS_EN is defined.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb0_valid,
  input  logic [REG_AW-1:0]        wb0_reg,
  input  logic [DATA_W-1:0]        wb0_data,
  output logic                     wb0_ready,
  input  logic                     wb1_valid,
  input  logic [REG_AW-1:0]        wb1_reg,
  input  logic [DATA_W-1:0]        wb1_data,
  output logic                     wb1_ready,
  output logic [REG_AW-1:0]        rf_write_reg,
  output logic [DATA_W-1:0]        rf_write_data,
  output logic                     rf_write_enable,
  output logic [(2**REG_AW)-1:0]   pend_mask
`ifdef RF_WRITE_ARB_STATS_EN
  ,
  output logic [15:0]              stat_coalesce,
  output logic [15:0]              stat_stall
`endif
);

  logic              h0_valid_q, h0_valid_d;
  logic [REG_AW-1:0] h0_reg_q;
  logic [DATA_W-1:0] h0_data_q;
  logic              h1_valid_q, h1_valid_d;
  logic [REG_AW-1:0] h1_reg_q;
  logic [DATA_W-1:0] h1_data_q;
  // older_q=1 means hold1 holds the older entry; only meaningful when both holds are valid
  logic              older_q, older_d;

  logic grant0, grant1, coalesce;
  logic free0, free1;
  logic load0, load1;

  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    coalesce = 1'b0;
    if (h0_valid_q && h1_valid_q) begin
      if (h0_reg_q == h1_reg_q) begin
        // Same destination: only the younger value matters, the older one is dropped
        coalesce = 1'b1;
        grant0   = older_q;
        grant1   = !older_q;
      end else begin
        grant0 = !older_q;
        grant1 = older_q;
      end
    end else begin
      grant0 = h0_valid_q;
      grant1 = h1_valid_q;
    end
  end

  assign free0     = grant0 | coalesce;
  assign free1     = grant1 | coalesce;
  assign wb0_ready = !h0_valid_q | grant0;
  assign wb1_ready = !h1_valid_q | grant1;
  assign load0     = wb0_valid & wb0_ready & (wb0_reg != '0);
  assign load1     = wb1_valid & wb1_ready & (wb1_reg != '0);

  always_comb begin
    h0_valid_d = load0 | (h0_valid_q & !free0);
    h1_valid_d = load1 | (h1_valid_q & !free1);
    older_d    = 1'b0;
    if (h0_valid_d && h1_valid_d) begin
      if (load0 && load1) begin
        older_d = 1'b0;
      end else if (load0) begin
        older_d = 1'b1;
      end else if (load1) begin
        older_d = 1'b0;
      end else begin
        older_d = older_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0_valid_q <= 1'b0;
      h0_reg_q   <= '0;
      h0_data_q  <= '0;
      h1_valid_q <= 1'b0;
      h1_reg_q   <= '0;
      h1_data_q  <= '0;
      older_q    <= 1'b0;
    end else begin
      h0_valid_q <= h0_valid_d;
      h1_valid_q <= h1_valid_d;
      older_q    <= older_d;
      if (load0) begin
        h0_reg_q  <= wb0_reg;
        h0_data_q <= wb0_data;
      end
      if (load1) begin
        h1_reg_q  <= wb1_reg;
        h1_data_q <= wb1_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= grant0 | grant1;
      if (grant0) begin
        rf_write_reg  <= h0_reg_q;
        rf_write_data <= h0_data_q;
      end else if (grant1) begin
        rf_write_reg  <= h1_reg_q;
        rf_write_data <= h1_data_q;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    if (h0_valid_q) pend_mask[h0_reg_q] = 1'b1;
    if (h1_valid_q) pend_mask[h1_reg_q] = 1'b1;
    if (rf_write_enable) pend_mask[rf_write_reg] = 1'b1;
  end

`ifdef RF_WRITE_ARB_STATS_EN
  logic [15:0] coal_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        stall;

  assign stall = (wb0_valid & !wb0_ready) | (wb1_valid & !wb1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coal_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (coalesce && (coal_cnt_q != 16'hFFFF)) coal_cnt_q <= coal_cnt_q + 16'd1;
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stat_coalesce = coal_cnt_q;
  assign stat_stall    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: age-ordered queue model plus a shadow register file.
module tb_rf_write_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb0_valid = 1'b0;
  logic [AW-1:0] wb0_reg = '0;
  logic [DW-1:0] wb0_data = '0;
  logic          wb0_ready;
  logic          wb1_valid = 1'b0;
  logic [AW-1:0] wb1_reg = '0;
  logic [DW-1:0] wb1_data = '0;
  logic          wb1_ready;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_write_data;
  logic          rf_write_enable;
  logic [31:0]   pend_mask;
`ifdef RF_WRITE_ARB_STATS_EN
  logic [15:0]   stat_coalesce;
  logic [15:0]   stat_stall;
`endif

  rf_write_arbiter #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb0_valid       (wb0_valid),
    .wb0_reg         (wb0_reg),
    .wb0_data        (wb0_data),
    .wb0_ready       (wb0_ready),
    .wb1_valid       (wb1_valid),
    .wb1_reg         (wb1_reg),
    .wb1_data        (wb1_data),
    .wb1_ready       (wb1_ready),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .pend_mask       (pend_mask)
`ifdef RF_WRITE_ARB_STATS_EN
    ,
    .stat_coalesce   (stat_coalesce),
    .stat_stall      (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lane;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  // Model: held writes in program order (oldest first) and the presented rf write
  ent_t          mq[$];
  logic          m_we;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;

  // Shadow register file from DUT writes vs. last program-order value per register
  logic [DW-1:0] shadow[32];
  bit            swr[32];
  logic [DW-1:0] golden[32];
  bit            gv[32];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic m_eval(output logic rd0, output logic rd1, output int widx, output bit both);
    widx = -1;
    both = 1'b0;
    if (mq.size() == 1) widx = 0;
    else if (mq.size() == 2) begin
      if (mq[0].r != mq[1].r) widx = 0;
      else begin
        widx = 1;
        both = 1'b1;
      end
    end
    rd0 = 1'b1;
    rd1 = 1'b1;
    foreach (mq[i]) begin
      if (i != widx) begin
        if (mq[i].lane == 0) rd0 = 1'b0;
        else rd1 = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].r] = 1'b1;
    if (m_we) p[m_reg] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    mq = {};
    m_we = 1'b0;
    m_reg = '0;
    m_data = '0;
    for (int i = 0; i < 32; i++) begin
      shadow[i] = '0;
      swr[i]    = 1'b0;
      golden[i] = '0;
      gv[i]     = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic rd0, rd1;
    int   widx;
    bit   both;
    m_eval(rd0, rd1, widx, both);
    chk("wb0_ready", 64'(wb0_ready), 64'(rd0));
    chk("wb1_ready", 64'(wb1_ready), 64'(rd1));
    chk("rf_write_enable", 64'(rf_write_enable), 64'(m_we));
    chk("pend_mask", 64'(pend_mask), 64'(m_pend()));
    if (m_we) begin
      chk("rf_write_reg", 64'(rf_write_reg), 64'(m_reg));
      chk("rf_write_data", 64'(rf_write_data), 64'(m_data));
    end
  endtask

  // Called at a negedge; applies one cycle of inputs, returns at the following negedge.
  task automatic step(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1);
    logic rd0, rd1;
    int   widx;
    bit   both;
    ent_t nq[$];
    ent_t e;
    logic          n_we;
    logic [AW-1:0] n_reg;
    logic [DW-1:0] n_data;
    if (rf_write_enable) begin
      shadow[rf_write_reg] = rf_write_data;
      swr[rf_write_reg]    = 1'b1;
    end
    wb0_valid = v0; wb0_reg = r0; wb0_data = d0;
    wb1_valid = v1; wb1_reg = r1; wb1_data = d1;
    m_eval(rd0, rd1, widx, both);
    nq = {};
    foreach (mq[i]) if (widx < 0 || (!both && i != widx)) nq.push_back(mq[i]);
    if (v0 && rd0 && r0 != 0) begin
      e.lane = 0; e.r = r0; e.d = d0;
      nq.push_back(e);
      golden[r0] = d0; gv[r0] = 1'b1;
    end
    if (v1 && rd1 && r1 != 0) begin
      e.lane = 1; e.r = r1; e.d = d1;
      nq.push_back(e);
      golden[r1] = d1; gv[r1] = 1'b1;
    end
    n_we   = (widx >= 0);
    n_reg  = n_we ? mq[widx].r : m_reg;
    n_data = n_we ? mq[widx].d : m_data;
    @(posedge clk);
    mq = nq;
    m_we = n_we;
    m_reg = n_reg;
    m_data = n_data;
    @(negedge clk);
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset rf_write_enable", 64'(rf_write_enable), 64'd0);
    chk("reset rf_write_reg", 64'(rf_write_reg), 64'd0);
    chk("reset rf_write_data", 64'(rf_write_data), 64'd0);
    chk("reset pend_mask", 64'(pend_mask), 64'd0);
    chk("reset ready", 64'({wb0_ready, wb1_ready}), 64'd3);

    // Single lane
    step(1'b1, 5'd2, 32'hFFFF_FFFF, 1'b0, '0, '0);
    chk("single pend held", 64'(pend_mask), 64'h4);
    chk("single we early", 64'(rf_write_enable), 64'd0);
    idle();
    chk("single we", 64'(rf_write_enable), 64'd1);
    chk("single reg", 64'(rf_write_reg), 64'd2);
    chk("single data", 64'(rf_write_data), 64'hFFFF_FFFF);
    chk("single pend presented", 64'(pend_mask), 64'h4);
    idle();
    chk("single done we", 64'(rf_write_enable), 64'd0);
    chk("single done pend", 64'(pend_mask), 64'd0);

    // Dual, distinct registers: lane 0 first
    step(1'b1, 5'd3, 32'h0000_000A, 1'b1, 5'd4, 32'h0000_0005);
    chk("dual ready", 64'({wb0_ready, wb1_ready}), 64'b10);
    idle();
    chk("dual first reg", 64'(rf_write_reg), 64'd3);
    chk("dual first data", 64'(rf_write_data), 64'hA);
    idle();
    chk("dual second reg", 64'(rf_write_reg), 64'd4);
    chk("dual second data", 64'(rf_write_data), 64'h5);

    // Coalesce on same register
    step(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222);
    idle();
    chk("coalesce we", 64'(rf_write_enable), 64'd1);
    chk("coalesce reg", 64'(rf_write_reg), 64'd5);
    chk("coalesce data", 64'(rf_write_data), 64'h2222_2222);
    idle();
    chk("coalesce single write", 64'(rf_write_enable), 64'd0);
`ifdef RF_WRITE_ARB_STATS_EN
    chk("stat_coalesce", 64'(stat_coalesce), 64'd1);
`endif

    // Age across cycles: held A is older than later B to the same register
    step(1'b1, 5'd7, 32'h0000_000C, 1'b1, 5'd6, 32'h0000_000A);
    step(1'b1, 5'd6, 32'h0000_000B, 1'b0, '0, '0);
    chk("age first reg", 64'(rf_write_reg), 64'd7);
    idle();
    chk("age reg6", 64'(rf_write_reg), 64'd6);
    chk("age reg6 data", 64'(rf_write_data), 64'hB);
    idle();
    chk("age no stale write", 64'(rf_write_enable), 64'd0);

    // Register zero dropped
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
    chk("zero pend", 64'(pend_mask), 64'd0);
    chk("zero ready", 64'(wb0_ready), 64'd1);
    idle();
    chk("zero we", 64'(rf_write_enable), 64'd0);

    // Reset mid-flight with both holds full
    step(1'b1, 5'd8, 32'h8888_8888, 1'b1, 5'd9, 32'h9999_9999);
    chk("pre-reset pend", 64'(pend_mask), 64'h300);
    rst_n = 1'b0;
    #1;
    chk("mid reset we", 64'(rf_write_enable), 64'd0);
    chk("mid reset pend", 64'(pend_mask), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle();
    chk("post reset we", 64'(rf_write_enable), 64'd0);
    idle();
    chk("post reset we2", 64'(rf_write_enable), 64'd0);

    // Randomized traffic over a small register set to provoke coalescing
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom);
    end
    repeat (4) idle();
    for (int r = 1; r < 32; r++) begin
      if (gv[r]) chk($sformatf("final reg%0d", r), 64'(shadow[r]), 64'(golden[r]));
      else chk($sformatf("unwritten reg%0d", r), 64'(swr[r]), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between the two writeback lanes of the superscalar pipeline.
- Each lane has a valid/ready handshake and a one-entry hold buffer.
- Held writes retire oldest-first, at most one per cycle, into the register file's write_reg/write_data/write_enable inputs.
- Exports a pending-write bitmap so issue logic can stall readers of registers whose writes have not landed yet.

Parameters:
- DATA_W, 32, width of write data.
- REG_AW, 5, register address width (2^REG_AW registers; register 0 is hardwired zero).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb0_valid  in  1  lane 0 write request.
- wb0_reg  in  REG_AW  lane 0 destination register.
- wb0_data  in  DATA_W  lane 0 write data.
- wb0_ready  out  1  lane 0 may transfer this cycle.
- wb1_valid, wb1_reg, wb1_data, wb1_ready: same as lane 0, for lane 1.
- rf_write_reg  out  REG_AW  register-file write address (registered).
- rf_write_data  out  DATA_W  register-file write data (registered).
- rf_write_enable  out  1  register-file write strobe (registered).
- pend_mask  out  2^REG_AW  bit r=1 while a write to register r is held or presented on the rf_* outputs.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - hold0/hold1 valid flags cleared; older flag set to 0.
  - rf_write_enable=0, rf_write_reg=0, rf_write_data=0.
  - pend_mask=0.
  - Reset asserted mid-operation discards all held writes; none reach the register file.
- Transfer: laneN transfers on a rising edge when wbN_valid & wbN_ready.
  - wbN_ready = !holdN_valid | grantN. Depends only on state, never on wbN_valid.
  - A transfer with wbN_reg==0 is accepted and dropped; the hold buffer is not written.
- Age tracking:
  - When both lanes transfer on the same edge, lane 0 is older (program order).
  - When one lane transfers while the other hold is still occupied, and that other entry is not granted on that edge, the held entry is older.
  - If the other entry is granted on that same edge, the new entry becomes the sole entry.
- Grant (combinational from holds):
  - Only one hold valid: grant it.
  - Both valid, different registers: grant the older entry.
  - Both valid, same register (coalesce): the older entry is discarded without writing. The younger entry is granted. Both holds free on that edge.
- Output stage, on each edge:
  - rf_write_enable <= any grant.
  - On a grant, rf_write_reg and rf_write_data are loaded from the granted entry; otherwise they hold their value.
- Latency: transfer at edge k puts the entry in hold after k. The earliest grant presents it on the rf_* outputs after edge k+1, and the register file writes at edge k+2.
- Throughput: one write per cycle sustained. With both lanes streaming, each lane sees ready on alternate cycles.
- pend_mask = decode(hold0) | decode(hold1) | (rf_write_enable ? decode(rf_write_reg) : 0). It is combinational from registered state.
- Never two writes to the same register in one cycle. Never an older write to a register landing after a younger write to the same register.

Optional Feature:
- Macro RF_WRITE_ARB_STATS_EN.
- Defined:
  - Adds output stat_coalesce (16 bits): increments on every coalesce.
  - Adds output stat_stall (16 bits): increments each cycle in which wb0_valid&!wb0_ready or wb1_valid&!wb1_ready.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single lane: wb0 {reg 2, FFFFFFFF} at edge 1 -> rf_write_enable=1, reg=2, data=FFFFFFFF after edge 2. pend_mask[2]=1 from edge 1 through edge 3, then 0.
- Dual, distinct: wb0 {3, 0000000A} and wb1 {4, 00000005} on the same edge -> register 3 written the cycle before register 4. wb0_ready=1, wb1_ready=0 for one cycle.
- Coalesce: wb0 {5, 11111111} and wb1 {5, 22222222} on the same edge -> exactly one write: reg 5 = 22222222. With the macro on, stat_coalesce=1.
- Age across cycles: wb1 {6, A} at edge 1, stalled, then wb0 {6, B} next -> final write to reg 6 = B, never A after B.
- Zero register: wb0 {0, FFFFFFFF} -> accepted, rf_write_enable stays 0, pend_mask stays 0.
- Reset mid-flight: both holds full, rst_n low between edges -> rf_write_enable=0 and pend_mask=0 immediately. No writes after release.
